// File: rtl/led7seg_pkg.sv
// Shared constants for the 4-digit hex 7-segment scanner.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}, dp always off.
package led7seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'b1111;

  // Entry n sits at HEX_SEG[n]; listed from F down to 0.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/led7seg_if.sv
// Display bus: value to show plus the active-low segment and digit-select drives.
// master supplies the value and observes the drives; slave is the scanner.
interface led7seg_if;

  logic [15:0] data;
  logic [7:0]  seg;
  logic [3:0]  segsel;

  modport master (
    output data,
    input  seg,
    input  segsel
  );

  modport slave (
    input  data,
    output seg,
    output segsel
  );

endinterface

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern (dp off).
// Zero latency, no state.
module hex7seg_decode
  import led7seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/led7seg.sv
// Time-multiplexed 4-digit hex display driver; outputs registered, 1-clock latency.
// Each digit holds for 2^SCAN_BITS clocks, the last of which is blanked against ghosting.
module led7seg
  import led7seg_pkg::*;
#(
  parameter int SCAN_BITS = 16
) (
  input  logic      clk,
  input  logic      reset,
  led7seg_if.slave  disp
);

  localparam logic [SCAN_BITS-1:0] PS_ONE = SCAN_BITS'(1);

  logic [SCAN_BITS-1:0] prescaler;
  logic [1:0]           digit_idx;
  logic                 slot_end;
  logic [3:0]           nib;
  logic [7:0]           nib_seg;
  logic [7:0]           seg_q;
  logic [3:0]           segsel_q;

  assign slot_end = &prescaler;

  // data is sampled live, never latched, so edits show on the active digit at once.
  always_comb begin
    nib = 4'h0;
    case (digit_idx)
      2'd0: nib = disp.data[3:0];
      2'd1: nib = disp.data[7:4];
      2'd2: nib = disp.data[11:8];
      2'd3: nib = disp.data[15:12];
      default: nib = 4'h0;
    endcase
  end

  hex7seg_decode u_decode (
    .nib (nib),
    .seg (nib_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      digit_idx <= 2'd0;
      seg_q     <= SEG_OFF;
      segsel_q  <= SEL_OFF;
    end else begin
      prescaler <= prescaler + PS_ONE;
      if (slot_end) begin
        digit_idx <= digit_idx + 2'd1;
        seg_q     <= SEG_OFF;
        segsel_q  <= SEL_OFF;
      end else begin
        seg_q     <= nib_seg;
        segsel_q  <= ~(4'b0001 << digit_idx);
      end
    end
  end

  assign disp.seg    = seg_q;
  assign disp.segsel = segsel_q;

endmodule

// File: tb/tb_led7seg.sv
// Bench for led7seg with SCAN_BITS=2: decode table vectors, scan sequences,
// live data update, asynchronous reset mid-scan and randomized data against a slot model.
module tb_led7seg;

  localparam int SB   = 2;
  localparam int SLOT = 1 << SB;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   k       = 0;

  led7seg_if dif ();

  led7seg #(.SCAN_BITS(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] nib;
    logic [7:0] seg;
  } dec_vec_t;

  dec_vec_t   vecs [16];
  logic [7:0] ref_tab [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Edge k (k>=1 after release) sees prescaler (k-1) mod SLOT and digit ((k-1)/SLOT) mod 4.
  task automatic check_model(input string tag);
    int pos;
    int idx;
    logic [15:0] sh;
    logic [3:0]  es;
    logic [7:0]  eseg;
    pos = (k - 1) % SLOT;
    idx = ((k - 1) / SLOT) % 4;
    if (pos == SLOT - 1) begin
      es   = 4'b1111;
      eseg = 8'hFF;
    end else begin
      es   = ~(4'b0001 << idx);
      sh   = dif.data >> (4 * idx);
      eseg = ref_tab[sh[3:0]];
    end
    check({tag, ".segsel"}, {12'h0, dif.segsel}, {12'h0, es});
    check({tag, ".seg"}, {8'h0, dif.seg}, {8'h0, eseg});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold.segsel", {12'h0, dif.segsel}, 16'h000F);
      check("rst_hold.seg", {8'h0, dif.seg}, 16'h00FF);
    end
    @(negedge clk);
    reset = 1'b1;
    k = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r;
    int ones;

    vecs[0]  = '{4'h0, 8'hC0}; vecs[1]  = '{4'h1, 8'hF9};
    vecs[2]  = '{4'h2, 8'hA4}; vecs[3]  = '{4'h3, 8'hB0};
    vecs[4]  = '{4'h4, 8'h99}; vecs[5]  = '{4'h5, 8'h92};
    vecs[6]  = '{4'h6, 8'h82}; vecs[7]  = '{4'h7, 8'hF8};
    vecs[8]  = '{4'h8, 8'h80}; vecs[9]  = '{4'h9, 8'h90};
    vecs[10] = '{4'hA, 8'h88}; vecs[11] = '{4'hB, 8'h83};
    vecs[12] = '{4'hC, 8'hC6}; vecs[13] = '{4'hD, 8'hA1};
    vecs[14] = '{4'hE, 8'h86}; vecs[15] = '{4'hF, 8'h8E};
    for (int i = 0; i < 16; i++) ref_tab[vecs[i].nib] = vecs[i].seg;

    // Reset held with clock running, then first edge after release.
    dif.data = 16'hABCD;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset.segsel", {12'h0, dif.segsel}, 16'h000F);
      check("reset.seg", {8'h0, dif.seg}, 16'h00FF);
    end
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    tick();
    check("first_edge.segsel", {12'h0, dif.segsel}, 16'h000E);
    check("first_edge.seg", {8'h0, dif.seg}, 16'h00A1);

    // Scan order on 1234.
    do_reset();
    dif.data = 16'h1234;
    for (int i = 0; i < 32; i++) begin
      tick();
      check_model("scan");
    end

    // Full decode on digit 0, one vector per fresh scan start.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      r = 16'($urandom);
      dif.data = {r[15:4], vecs[i].nib};
      tick();
      check("decode.segsel", {12'h0, dif.segsel}, 16'h000E);
      check("decode.seg", {8'h0, dif.seg}, {8'h0, vecs[i].seg});
      check("decode.dp", {15'h0, dif.seg[7]}, 16'h0001);
    end

    // Live update mid-slot.
    do_reset();
    dif.data = 16'h0000;
    tick();
    check("live0.seg", {8'h0, dif.seg}, 16'h00C0);
    dif.data = 16'hFFFF;
    tick();
    check("live1.segsel", {12'h0, dif.segsel}, 16'h000E);
    check("live1.seg", {8'h0, dif.seg}, 16'h008E);
    for (int i = 0; i < 14; i++) begin
      tick();
      check_model("live");
    end

    // Asynchronous reset while digit 2 is lit.
    do_reset();
    dif.data = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_model("pre_arst");
    end
    check("arst_lit.segsel", {12'h0, dif.segsel}, 16'h000B);
    check("arst_lit.seg", {8'h0, dif.seg}, 16'h00A4);
    #2;
    reset = 1'b0;
    #1;
    check("arst.segsel", {12'h0, dif.segsel}, 16'h000F);
    check("arst.seg", {8'h0, dif.seg}, 16'h00FF);
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    tick();
    check("arst_resume.segsel", {12'h0, dif.segsel}, 16'h000E);
    check("arst_resume.seg", {8'h0, dif.seg}, 16'h0099);

    // Random data every clock against the slot model and output invariants.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      dif.data = 16'($urandom);
      tick();
      check_model("rand");
      ones = $countones(~dif.segsel);
      check("rand.onehot", {15'h0, (ones > 1)}, 16'h0000);
      check("rand.blank", {15'h0, (dif.segsel == 4'b1111 && dif.seg != 8'hFF)}, 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
